tdpr_port_arbiter: RTL and testbench
====================================

// Module: tdpr_port_arbiter
// PURPOSE
//  Shares one True_DPR instance (two symmetric ports, A and B) among NUM_REQ requesters.
//  Each cycle it grants up to two requests: the first to port A, the second to port B.
//  It blocks same-address hazards between ports and routes registered read data back to the owner.
//  It sits directly in front of the RAM; the RAM is instantiated beside it, one level up.
// PARAMETERS
//  NUM_REQ   4  number of requesters, >=2
//  ADDR_SIZE 8  RAM address width
//  DATA_SIZE 8  RAM data width
// PORTS
//  clk     in   1                  single clock; all state on posedge
//  rst_n   in   1                  asynchronous active-low reset
//  req     in   NUM_REQ            request; held until granted
//  req_we  in   NUM_REQ            1=write, 0=read; valid with req
//  req_addr in  NUM_REQ*ADDR_SIZE  flattened, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
//  req_din in   NUM_REQ*DATA_SIZE  write data, flattened likewise
//  gnt     out  NUM_REQ            one-hot-per-port grant; request accepted this cycle
//  rvalid  out  NUM_REQ            read data valid for requester i
//  rdata   out  NUM_REQ*DATA_SIZE  read data, flattened
//  en_a/we_a, en_b/we_b   out 1    RAM port enables and write enables
//  addr_a, addr_b         out ADDR_SIZE  RAM addresses
//  din_a, din_b           out DATA_SIZE  RAM write data
//  dout_a, dout_b         in  DATA_SIZE  RAM read data, 1-cycle synchronous read
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): rr_ptr=0 and both response-owner registers invalid.
//    While rst_n is low, gnt, rvalid, en_*, we_* are forced to 0; rdata, addr_*, din_* are 0.
//    In-flight reads are dropped: no rvalid after reset deasserts.
//  - Selection (combinational, same cycle):
//    - winner A = first requester with req=1, searching circularly from rr_ptr.
//    - winner B = next requester with req=1 after A in the same circular order.
//  - Hazard: if addr_A==addr_B and (we_A|we_B), B is not granted and retries next cycle.
//    Two reads of the same address are both granted.
//  - Grant: gnt[i]=1 drives port signals from requester i in that cycle.
//    The RAM samples at the next edge; the requester drops or changes req after a gnt edge.
//    A request is never granted to both ports.
//  - Pointer: on any cycle with >=1 grant, rr_ptr <= (last granted index + 1) mod NUM_REQ.
//    The last granted index is B if B was granted, else A. With no grant, rr_ptr holds.
//    Every requester holding req is granted within NUM_REQ-1 cycles.
//  - Read return: a read granted in cycle t asserts rvalid[i] for exactly one cycle at t+1.
//    rdata slice i then equals dout of the port used; other slices hold 0.
//    Writes produce no rvalid.
//  - Port A and B returns can target different requesters in the same cycle.
//  - No grants: en_a=en_b=0; outputs idle at 0.
//  - Arithmetic: index math is $clog2(NUM_REQ) bits wide; the wrap uses explicit compare.
//    This keeps non-power-of-two NUM_REQ correct.
// STRUCTURE
//  - Package tdpr_pkg: default ADDR_SIZE/DATA_SIZE/NUM_REQ, and localparam PORT_A=0, PORT_B=1.
//    It also holds a function for the flattened-slice index.
//  - Sub-module tdpr_rr_pick: a circular first-set finder (vector, start index -> found, index).
//    It is instantiated twice: A from rr_ptr, B from A+1 with A masked.
//  - Top level holds rr_ptr, the hazard compare, port muxes, and two owner registers.
//    Each owner register is a valid bit plus an index, one per port.
// TESTING
//  1. Reset: assert rst_n=0 mid-read (read granted, edge pending).
//     -> gnt=0, rvalid=0, en_a=en_b=0; no rvalid after release.
//  2. Single write then read: req0 writes 0xA5 to addr 0x10, then reads 0x10.
//     -> gnt[0] both times on port A; rvalid[0]=1 one cycle after the read grant; rdata0=0xA5.
//  3. Dual grant: req1 reads 0x03 and req2 writes 0x3C to 0x04, with rr_ptr=0.
//     -> gnt=0110, req1 on A, req2 on B; rvalid[1] next cycle; rr_ptr becomes 3.
//  4. Hazard: req0 writes 0x20 and req1 reads 0x20 in the same cycle.
//     -> only gnt[0]; gnt[1] next cycle; rdata1 shows the newly written value.
//  5. Fairness: all 4 requesters hold reads for 8 cycles.
//     -> grants rotate {0,1},{2,3},{0,1}...; no requester waits more than 1 cycle.
//  6. Same-address double read: req2 and req3 both read 0x7F (=0x11).
//     -> both granted; rvalid=1100 next cycle; rdata2=rdata3=0x11.

Source files
------------

// File: rtl/tdpr_pkg.sv
// Shared definitions for the True_DPR port arbiter.
// Holds the default geometry, the port identifiers used to index the
// per-port owner registers, and a helper for locating a requester's slice
// inside a flattened bus.
package tdpr_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int ADDR_SIZE_DEF = 8;
  localparam int DATA_SIZE_DEF = 8;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  // Low bit of requester idx's field in a bus flattened at 'width' bits per requester
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/tdpr_rr_pick.sv
// Circular first-set finder.
// Ports:
//   vec_i    candidate vector
//   start_i  index where the circular search begins
//   found_o  at least one bit of vec_i is set
//   idx_o    first set index at or after start_i, wrapping past N-1 to 0
module tdpr_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] pos_s;
  logic          bit_s;
  logic          hit_s;

  // Walk N positions from start_i; the wrap uses a compare so non-power-of-two N works
  always_comb begin
    found_o = 1'b0;
    idx_o   = {IW{1'b0}};
    pos_s   = start_i;
    bit_s   = 1'b0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      bit_s = 1'b0;
      for (int j = 0; j < N; j++) begin
        bit_s = bit_s | ((pos_s == IW'(j)) & vec_i[j]);
      end
      hit_s   = ~found_o & bit_s;
      idx_o   = hit_s ? pos_s : idx_o;
      found_o = found_o | bit_s;
      pos_s   = (pos_s == LAST) ? {IW{1'b0}} : pos_s + IW'(1);
    end
  end

endmodule

// File: rtl/tdpr_port_arbiter.sv
// Shares one true dual-port RAM between NUM_REQ requesters.
// Each cycle the first requester found from rr_ptr gets port A and the next
// one after it gets port B, unless both target the same address and either
// writes, in which case B waits. Read data comes back one cycle later and is
// steered to the requester that owned the port.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req/req_we/req_addr/req_din     per-requester request, flattened buses
//   gnt                             request accepted this cycle
//   rvalid/rdata                    per-requester read return, flattened
//   en_*/we_*/addr_*/din_*          RAM port controls (A and B)
//   dout_a, dout_b                  RAM read data, one cycle after the enable
import tdpr_pkg::*;

module tdpr_port_arbiter #(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_din,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [NUM_REQ*DATA_SIZE-1:0]   rdata,
  output logic                           en_a,
  output logic                           we_a,
  output logic                           en_b,
  output logic                           we_b,
  output logic [ADDR_SIZE-1:0]           addr_a,
  output logic [ADDR_SIZE-1:0]           addr_b,
  output logic [DATA_SIZE-1:0]           din_a,
  output logic [DATA_SIZE-1:0]           din_b,
  input  logic [DATA_SIZE-1:0]           dout_a,
  input  logic [DATA_SIZE-1:0]           dout_b
);

  localparam int            IW   = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [1:0]              own_vld_q, own_vld_d;
  logic [1:0][IW-1:0]      own_idx_q, own_idx_d;

  logic                    a_found_s, b_found_s, b_gnt_s, hazard_s;
  logic [IW-1:0]           a_idx_s, b_idx_s, b_start_s, last_s;
  logic [NUM_REQ-1:0]      b_vec_s, gnt_s;
  logic                    a_we_s, b_we_s;
  logic [ADDR_SIZE-1:0]    a_addr_s, b_addr_s;
  logic [DATA_SIZE-1:0]    a_din_s, b_din_s;
  logic [NUM_REQ-1:0]      rvalid_s;
  logic [NUM_REQ*DATA_SIZE-1:0] rdata_s;

  tdpr_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_a (
    .vec_i   (req),
    .start_i (rr_ptr_q),
    .found_o (a_found_s),
    .idx_o   (a_idx_s)
  );

  // B searches from just after A with A's own bit removed, so one request never gets both ports
  always_comb begin
    b_start_s = (a_idx_s == LAST) ? {IW{1'b0}} : a_idx_s + IW'(1);
    b_vec_s   = req;
    for (int i = 0; i < NUM_REQ; i++) begin
      b_vec_s[i] = req[i] & ~(a_found_s & (a_idx_s == IW'(i)));
    end
  end

  tdpr_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_b (
    .vec_i   (b_vec_s),
    .start_i (b_start_s),
    .found_o (b_found_s),
    .idx_o   (b_idx_s)
  );

  // AND-OR mux of the winners' request fields
  always_comb begin
    a_we_s   = 1'b0;
    b_we_s   = 1'b0;
    a_addr_s = {ADDR_SIZE{1'b0}};
    b_addr_s = {ADDR_SIZE{1'b0}};
    a_din_s  = {DATA_SIZE{1'b0}};
    b_din_s  = {DATA_SIZE{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      a_we_s   = a_we_s | ((a_idx_s == IW'(i)) & req_we[i]);
      b_we_s   = b_we_s | ((b_idx_s == IW'(i)) & req_we[i]);
      a_addr_s = a_addr_s | ({ADDR_SIZE{a_idx_s == IW'(i)}} & req_addr[slice_lo(i, ADDR_SIZE) +: ADDR_SIZE]);
      b_addr_s = b_addr_s | ({ADDR_SIZE{b_idx_s == IW'(i)}} & req_addr[slice_lo(i, ADDR_SIZE) +: ADDR_SIZE]);
      a_din_s  = a_din_s  | ({DATA_SIZE{a_idx_s == IW'(i)}} & req_din[slice_lo(i, DATA_SIZE) +: DATA_SIZE]);
      b_din_s  = b_din_s  | ({DATA_SIZE{b_idx_s == IW'(i)}} & req_din[slice_lo(i, DATA_SIZE) +: DATA_SIZE]);
    end
  end

  // Same-address access with a write on either side would race inside the RAM; B yields
  assign hazard_s = a_found_s & b_found_s & (a_addr_s == b_addr_s) & (a_we_s | b_we_s);
  assign b_gnt_s  = b_found_s & ~hazard_s;

  // Grant vector from the two port winners
  always_comb begin
    gnt_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_s[i] = (a_found_s & (a_idx_s == IW'(i))) | (b_gnt_s & (b_idx_s == IW'(i)));
    end
  end

  assign gnt    = rst_n ? gnt_s : {NUM_REQ{1'b0}};
  assign en_a   = rst_n & a_found_s;
  assign we_a   = rst_n & a_found_s & a_we_s;
  assign addr_a = (rst_n & a_found_s) ? a_addr_s : {ADDR_SIZE{1'b0}};
  assign din_a  = (rst_n & a_found_s) ? a_din_s  : {DATA_SIZE{1'b0}};
  assign en_b   = rst_n & b_gnt_s;
  assign we_b   = rst_n & b_gnt_s & b_we_s;
  assign addr_b = (rst_n & b_gnt_s) ? b_addr_s : {ADDR_SIZE{1'b0}};
  assign din_b  = (rst_n & b_gnt_s) ? b_din_s  : {DATA_SIZE{1'b0}};

  // Next pointer follows the last granted index; owners remember who reads on each port
  always_comb begin
    last_s = b_gnt_s ? b_idx_s : a_idx_s;
    if (a_found_s) begin
      rr_ptr_d = (last_s == LAST) ? {IW{1'b0}} : last_s + IW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    own_vld_d              = 2'b00;
    own_idx_d              = {2{ {IW{1'b0}} }};
    own_vld_d[PORT_A]      = a_found_s & ~a_we_s;
    own_idx_d[PORT_A]      = a_idx_s;
    own_vld_d[PORT_B]      = b_gnt_s & ~b_we_s;
    own_idx_d[PORT_B]      = b_idx_s;
  end

  // State registers; reset drops any read still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= {IW{1'b0}};
      own_vld_q <= 2'b00;
      own_idx_q <= {2{ {IW{1'b0}} }};
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      own_vld_q <= own_vld_d;
      own_idx_q <= own_idx_d;
    end
  end

  // Steer each port's registered read data to its owner; other slices stay 0
  always_comb begin
    rvalid_s = {NUM_REQ{1'b0}};
    rdata_s  = {(NUM_REQ*DATA_SIZE){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_s[i] = (own_vld_q[PORT_A] & (own_idx_q[PORT_A] == IW'(i))) |
                    (own_vld_q[PORT_B] & (own_idx_q[PORT_B] == IW'(i)));
      rdata_s[slice_lo(i, DATA_SIZE) +: DATA_SIZE] =
          ({DATA_SIZE{own_vld_q[PORT_A] & (own_idx_q[PORT_A] == IW'(i))}} & dout_a) |
          ({DATA_SIZE{own_vld_q[PORT_B] & (own_idx_q[PORT_B] == IW'(i))}} & dout_b);
    end
  end

  assign rvalid = rvalid_s;
  assign rdata  = rdata_s;

endmodule

// File: tb/tb_tdpr_port_arbiter.sv
// Bench for tdpr_port_arbiter: a behavioural dual-port RAM sits beside the
// DUT; expected grants are given per step, expected read returns are built
// from a shadow memory and queued, then compared after the clock edge.
module tb_tdpr_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, req_we;
  logic [31:0] req_addr, req_din;
  logic [3:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        en_a, we_a, en_b, we_b;
  logic [7:0]  addr_a, addr_b, din_a, din_b;
  logic [7:0]  dout_a, dout_b;

  logic [7:0]  ram    [256];
  logic [7:0]  sb_mem [256];

  typedef struct packed {
    logic [3:0]  rv;
    logic [31:0] rd;
  } exp_t;
  exp_t sb_q [$];

  int n_total;
  int n_bad;

  tdpr_port_arbiter #(.NUM_REQ(4), .ADDR_SIZE(8), .DATA_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .en_a(en_a), .we_a(we_a), .en_b(en_b), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .dout_a(dout_a), .dout_b(dout_b)
  );

  always #5 clk = ~clk;

  // Behavioural true dual-port RAM with a one-cycle synchronous read
  always @(posedge clk) begin
    if (en_a) begin
      if (we_a) ram[addr_a] <= din_a;
      else      dout_a      <= ram[addr_a];
    end
    if (en_b) begin
      if (we_b) ram[addr_b] <= din_b;
      else      dout_b      <= ram[addr_b];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_all();
    req = 4'b0; req_we = 4'b0; req_addr = 32'b0; req_din = 32'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*8 +: 8] = a;
    req_din[i*8 +: 8] = d;
  endtask

  // One arbitration cycle: called just after a negedge with inputs already set
  task automatic cyc(input string tag, input logic [3:0] exp_gnt);
    exp_t e;
    #1;
    check({tag, ".gnt"}, 64'(gnt), 64'(exp_gnt));
    check({tag, ".en_a"}, 64'(en_a), 64'(|exp_gnt));
    check({tag, ".en_b"}, 64'(en_b), 64'($countones(exp_gnt) == 2));
    e.rv = 4'b0;
    e.rd = 32'b0;
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i] && !req_we[i]) begin
        e.rv[i] = 1'b1;
        e.rd[i*8 +: 8] = sb_mem[req_addr[i*8 +: 8]];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i] && req_we[i]) sb_mem[req_addr[i*8 +: 8]] = req_din[i*8 +: 8];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".rvalid"}, 64'(rvalid), 64'(e.rv));
    check({tag, ".rdata"}, 64'(rdata), 64'(e.rd));
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clk     = 1'b0;
    rst_n   = 1'b0;
    dout_a  = 8'h00;
    dout_b  = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 8'h00;
      sb_mem[i] = 8'h00;
    end
    clr_all();
    repeat (2) @(negedge clk);

    // Reset holds every control low even with all requests raised
    req = 4'b1111;
    #1;
    check("rst.gnt", 64'(gnt), 64'h0);
    check("rst.en", 64'({en_a, en_b, we_a, we_b}), 64'h0);
    check("rst.rvalid", 64'(rvalid), 64'h0);
    check("rst.addr", 64'({addr_a, addr_b}), 64'h0);
    clr_all();
    @(negedge clk);
    rst_n = 1'b1;

    cyc("idle", 4'b0000);

    // Reset arriving while a read is granted and its edge is pending
    set_req(0, 1'b0, 8'h10, 8'h00);
    #1;
    check("midrst.gnt_pre", 64'(gnt), 64'h1);
    rst_n = 1'b0;
    #1;
    check("midrst.gnt", 64'(gnt), 64'h0);
    check("midrst.en", 64'({en_a, en_b}), 64'h0);
    @(posedge clk);
    #1;
    check("midrst.rvalid_in", 64'(rvalid), 64'h0);
    @(negedge clk);
    clr_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.rvalid_after", 64'(rvalid), 64'h0);
    @(negedge clk);

    // Single write then read on port A
    set_req(0, 1'b1, 8'h10, 8'hA5);
    #1;
    check("wr.we_a", 64'({we_a, addr_a, din_a}), {47'h0, 1'b1, 8'h10, 8'hA5});
    cyc("wr", 4'b0001);
    clr_all(); set_req(0, 1'b0, 8'h10, 8'h00);
    cyc("rd", 4'b0001);

    // Pointer is at 1; a lone grant to 3 wraps it back to 0
    clr_all(); set_req(3, 1'b0, 8'h10, 8'h00);
    cyc("wrap", 4'b1000);

    // Dual grant: 1 reads on A, 2 writes on B; pointer becomes 3
    clr_all(); set_req(1, 1'b0, 8'h03, 8'h00); set_req(2, 1'b1, 8'h04, 8'h3C);
    cyc("dual", 4'b0110);
    // From pointer 3: A=3, B=0; both ports return to different requesters
    clr_all(); set_req(0, 1'b0, 8'h04, 8'h00); set_req(3, 1'b0, 8'h10, 8'h00);
    cyc("split", 4'b1001);
    clr_all(); set_req(3, 1'b0, 8'h10, 8'h00);
    cyc("wrap2", 4'b1000);

    // Hazard: write and read of the same address; B waits one cycle
    clr_all(); set_req(0, 1'b1, 8'h20, 8'h5A); set_req(1, 1'b0, 8'h20, 8'h00);
    cyc("haz", 4'b0001);
    req[0] = 1'b0;
    cyc("haz_retry", 4'b0010);

    // Fairness from pointer 2 with all four holding reads
    clr_all();
    set_req(0, 1'b0, 8'h10, 8'h00); set_req(1, 1'b0, 8'h04, 8'h00);
    set_req(2, 1'b0, 8'h20, 8'h00); set_req(3, 1'b0, 8'h03, 8'h00);
    for (int k = 0; k < 8; k++) begin
      cyc("fair", (k % 2 == 0) ? 4'b1100 : 4'b0011);
    end

    // Same-address double read is not a hazard
    clr_all(); set_req(2, 1'b1, 8'h7F, 8'h11);
    cyc("prep7f", 4'b0100);
    clr_all(); set_req(2, 1'b0, 8'h7F, 8'h00); set_req(3, 1'b0, 8'h7F, 8'h00);
    cyc("dblrd", 4'b1100);

    clr_all();
    cyc("idle_end", 4'b0000);
    check("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
